// File: rtl/lw_sha_job_arbiter.sv
// Round-robin arbiter sharing one lw_hmac core between two requesters.
// The grant is held for a whole job: start, data stream, done or abort.
module lw_sha_job_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    areset_i,
  input  logic [1:0]              req_i,
  input  logic [7:0]              opcode_i,
  input  logic [1:0]              valid_i,
  input  logic [1:0]              last_i,
  input  logic [1:0]              abort_i,
  input  logic [2*DATA_WIDTH-1:0] data_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              ready_o,
  output logic [1:0]              done_o,
  output logic [8*DATA_WIDTH-1:0] hash_o,
  output logic                    fault_o,
  output logic                    core_start_o,
  output logic                    core_abort_o,
  output logic                    core_last_o,
  output logic                    core_valid_o,
  output logic [3:0]              core_opcode_o,
  output logic [DATA_WIDTH-1:0]   core_data_o,
  input  logic                    core_ready_i,
  input  logic                    core_idle_i,
  input  logic                    core_done_i,
  input  logic                    core_fault_i,
  input  logic [8*DATA_WIDTH-1:0] core_hash_i
);

  typedef enum logic [2:0] {
    StIdle, StStart, StStream, StWaitDone, StResult, StAbort, StFault
  } state_e;

  state_e                  state_q, state_d;
  logic                    rr_ptr_q, rr_ptr_d;
  logic                    sel_q, sel_d;
  logic                    first_q, first_d;
  logic [3:0]              opcode_q, opcode_d;
  logic [8*DATA_WIDTH-1:0] hash_q, hash_d;

  logic                  win;
  logic                  valid_sel, last_sel, abort_sel;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [1:0]            sel_oh;

  assign valid_sel = sel_q ? valid_i[1] : valid_i[0];
  assign last_sel  = sel_q ? last_i[1]  : last_i[0];
  assign abort_sel = sel_q ? abort_i[1] : abort_i[0];
  assign data_sel  = sel_q ? data_i[2*DATA_WIDTH-1:DATA_WIDTH] : data_i[DATA_WIDTH-1:0];
  assign sel_oh    = sel_q ? 2'b10 : 2'b01;
  // Lone requester wins outright; on contention the round-robin pointer decides.
  assign win       = (req_i == 2'b11) ? rr_ptr_q : req_i[1];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    opcode_d = opcode_q;
    hash_d   = hash_q;
    unique case (state_q)
      StIdle: begin
        if (core_idle_i && (req_i != 2'b00)) begin
          sel_d    = win;
          opcode_d = win ? opcode_i[7:4] : opcode_i[3:0];
          state_d  = StStart;
        end
      end
      StStart: state_d = abort_sel ? StAbort : StStream;
      StStream: begin
        if (abort_sel) begin
          state_d = StAbort;
        end else if (valid_sel && last_sel && core_ready_i) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (core_done_i) begin
          hash_d  = core_hash_i;
          state_d = StResult;
        end else if (abort_sel) begin
          state_d = StAbort;
        end
      end
      StResult: begin
        rr_ptr_d = ~sel_q;
        state_d  = StIdle;
      end
      StAbort: begin
        if (core_idle_i) begin
          rr_ptr_d = ~sel_q;
          state_d  = StIdle;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
    // A core fault overrides every other update made this cycle.
    if (core_fault_i) begin
      state_d  = StFault;
      rr_ptr_d = rr_ptr_q;
      sel_d    = sel_q;
      opcode_d = opcode_q;
      hash_d   = hash_q;
    end
    first_d = (state_d != state_q);
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      sel_q    <= 1'b0;
      first_q  <= 1'b0;
      opcode_q <= 4'h0;
      hash_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      first_q  <= first_d;
      opcode_q <= opcode_d;
      hash_q   <= hash_d;
    end
  end

  always_comb begin
    gnt_o         = 2'b00;
    ready_o       = 2'b00;
    done_o        = 2'b00;
    core_start_o  = 1'b0;
    core_valid_o  = 1'b0;
    core_last_o   = 1'b0;
    core_data_o   = '0;
    core_opcode_o = opcode_q;
    hash_o        = hash_q;
    fault_o       = (state_q == StFault);
    // Abort is a single pulse on entry to either the abort or the fault state.
    core_abort_o  = first_q && ((state_q == StAbort) || (state_q == StFault));
    if ((state_q != StIdle) && (state_q != StFault)) begin
      gnt_o = sel_oh;
    end
    if (state_q == StStart) begin
      core_start_o = 1'b1;
    end
    if (state_q == StStream) begin
      core_valid_o = valid_sel && !abort_sel;
      core_last_o  = core_valid_o && last_sel;
      core_data_o  = data_sel;
      ready_o      = core_ready_i ? sel_oh : 2'b00;
    end
    if (state_q == StResult) begin
      done_o = sel_oh;
    end
  end

endmodule

// File: doc/lw_sha_job_arbiter.md
# lw_sha_job_arbiter

Shares the single lw_hmac core between two independent message requesters, for example a CPU register path and a DMA channel. The block grants the core to one requester at a time, round-robin, and holds the grant for a whole job (start → last beat → done). It sequences the core's start, abort and data handshake, then returns the digest to the owning requester. It sits between the requester-side native interfaces and the lw_hmac native port.

## Interface
- DATA_WIDTH, 32 — data word width; hash is 8 words
- clk_i  in  1  core clock, all state on rising edge
- areset_i  in  1  asynchronous, active-high reset
- req_i  in  2  per-requester job request (level)
- opcode_i  in  8  opcode of requester r at bits [4r+3:4r]
- valid_i  in  2  per-requester data beat valid
- last_i  in  2  per-requester last-beat flag, qualified by valid_i
- abort_i  in  2  per-requester abort (level, sampled each cycle)
- data_i  in  2*DATA_WIDTH  data of requester r at [DATA_WIDTH*(r+1)-1 : DATA_WIDTH*r]
- gnt_o  out  2  one-hot grant, held for the whole job
- ready_o  out  2  per-requester beat ready
- done_o  out  2  one-cycle job-complete pulse to the owner
- hash_o  out  8*DATA_WIDTH  registered digest; valid while done_o is high, held afterwards
- fault_o  out  1  sticky fault flag
- core_start_o, core_abort_o, core_last_o, core_valid_o  out  1  to lw_hmac
- core_opcode_o  out  4  to lw_hmac; latched opcode
- core_data_o  out  DATA_WIDTH  to lw_hmac
- core_ready_i, core_idle_i, core_done_i, core_fault_i  in  1  from lw_hmac (ready_o, core_ready_o, done_o, fault_inj_det_o)
- core_hash_i  in  8*DATA_WIDTH  from lw_hmac hash_o, word 0 at LSBs

## Operation
- Reset: state IDLE, rr_ptr=0 (requester 0 preferred), sel=0. All outputs 0, hash_o=0, fault_o=0.
- **IDLE**: arbitration runs only when core_idle_i=1 and req_i≠0.
  - If exactly one requester is requesting, it wins.
  - If both are requesting, requester rr_ptr wins.
  - On a win, latch sel and opcode_i[sel], then go to START.
- **START**: core_start_o=1 and core_opcode_o=latched opcode for exactly 1 cycle; go to STREAM.
- **STREAM**: mux the selected requester onto the core.
  - core_valid_o=valid_i[sel], core_last_o=last_i[sel]&valid_i[sel], core_data_o=data slice [sel].
  - ready_o[sel]=core_ready_i; ready_o of the other requester is 0.
  - A beat is accepted when valid & ready. An accepted beat with last set goes to WAIT_DONE.
- **WAIT_DONE**: ready_o=0 and core_valid_o=0. On core_done_i, register core_hash_i into hash_o and go to RESULT.
- **RESULT**: done_o[sel]=1 for 1 cycle, rr_ptr←~sel, go to IDLE.
- **ABORT**: abort_i[sel]=1 in START, STREAM or WAIT_DONE moves the block to ABORT.
  - core_abort_o=1 on the first ABORT cycle only; no done_o is issued.
  - The block waits for core_idle_i=1, then sets rr_ptr←~sel and returns to IDLE.
- **FAULT**: core_fault_i=1 in any state forces FAULT.
  - fault_o=1 and gnt_o=0, and core_abort_o pulses once.
  - The block stays in FAULT until areset_i.
- gnt_o[sel]=1 in START, STREAM, WAIT_DONE, RESULT and ABORT; 0 in IDLE and FAULT.
- Outside STREAM, core_valid_o, core_last_o and all ready_o are 0 and core_data_o=0.
- Boundary rules:
  - req_i dropping mid-job is ignored; only abort_i ends a job early.
  - abort_i from the non-granted requester is ignored.
  - abort_i[sel] and an accepted last beat in the same cycle: abort wins and core_valid_o is gated to 0 that cycle.
  - core_done_i and abort_i[sel] in the same WAIT_DONE cycle: done wins.
  - core_fault_i has priority over everything.
  - areset_i mid-job clears to IDLE immediately. The core is reset alongside, so no abort is issued.

## Timing
- Request in IDLE at cycle T (core idle) → gnt_o and core_start_o at T+1; earliest beat acceptance at T+2.
- ready_o and core_valid_o are combinational from core_ready_i and valid_i, gated by registered state; no added beat latency.
- core_done_i at cycle D → hash_o updated and done_o pulse at D+1. IDLE at D+2, so the next grant can occur at D+3.
- Job turnaround overhead: 1 start cycle + 2 result cycles.

## Test plan
- Single job: req_i=01, opcode 4'h2, 3 beats with last on the 3rd, core_done_i 20 cycles later → gnt_o=01 from T+1, one core_start_o, 3 core beats, done_o=01 one cycle, hash_o=core_hash_i.
- Contention: req_i=11 from reset → requester 0 served first, then requester 1 with no intervening grant to 0. Repeating with both still requesting alternates 0,1,0.
- Backpressure: core_ready_i toggling 1010 while valid_i[0]=1 → exactly one beat per core_ready_i high; ready_o[1] stays 0.
- Abort mid-stream: abort_i[1] after 2 beats → core_abort_o one-cycle pulse, no done_o, IDLE after core_idle_i, rr_ptr=0.
- Same-cycle corner cases: last beat with abort_i[sel] → core_valid_o=0 and an abort is issued. core_done_i with abort_i in WAIT_DONE → done_o issued, no abort.
- Fault and reset: core_fault_i pulse during STREAM → fault_o=1 sticky, gnt_o=0, and further req_i is ignored. areset_i asserted mid-job → all outputs 0 asynchronously, then normal arbitration after release.
